// File: rtl/spmv_pkg.sv
// Shared constants, FSM state type and burst sizing helper for the SpMV Val fetch path.
package spmv_pkg;

    localparam logic [2:0]  AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned BEAT_BYTES     = 32;
    localparam int unsigned PAGE_BYTES     = 4096;
    localparam int unsigned PAGE_BEATS     = PAGE_BYTES / BEAT_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fsm_e;

    // Beats in the next burst: limited by the burst cap, the beats left and the 4 KB page end.
    // page_beat is the beat index within the current page (address bits [11:5]).
    function automatic logic [7:0] burst_len(input logic [6:0]  page_beat,
                                             input logic [31:0] remaining,
                                             input logic [7:0]  max_burst);
        logic [8:0] to_page;
        logic [7:0] len;
        to_page = 9'(PAGE_BEATS) - 9'(page_beat);
        len     = max_burst;
        if (remaining < 32'(len)) begin
            len = 8'(remaining);
        end
        if (to_page < 9'(len)) begin
            len = 8'(to_page);
        end
        return len;
    endfunction

endpackage

// File: rtl/spmv_stream_fifo.sv
// First-word-fall-through beat buffer with occupancy count.
// Ports: push/push_data write side; pop/pop_data/valid read side (pop_data valid while valid=1);
// count is the number of stored entries (0..DEPTH).
module spmv_stream_fifo #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid    = (count != '0);
    assign do_pop   = pop && valid;
    assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spmv_val_fetch.sv
// AXI4 read master streaming one kernel's Val array from HBM into an AXI-Stream.
// Ports: start/cfg_* program a fetch; busy/done/err report status; m_axi_Val_ar*/r* read
// channels (write channels tied off); m_axis_* value stream with tlast on the final beat.
module spmv_val_fetch
    import spmv_pkg::*;
#(
    parameter int unsigned ADDR_W     = 48,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [31:0]         cfg_num_beats,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   m_axi_Val_araddr,
    output logic [7:0]          m_axi_Val_arlen,
    output logic [2:0]          m_axi_Val_arsize,
    output logic [1:0]          m_axi_Val_arburst,
    output logic                m_axi_Val_arvalid,
    input  logic                m_axi_Val_arready,
    input  logic [DATA_W-1:0]   m_axi_Val_rdata,
    input  logic [1:0]          m_axi_Val_rresp,
    input  logic                m_axi_Val_rlast,
    input  logic                m_axi_Val_rvalid,
    output logic                m_axi_Val_rready,
    output logic [ADDR_W-1:0]   m_axi_Val_awaddr,
    output logic [7:0]          m_axi_Val_awlen,
    output logic [2:0]          m_axi_Val_awsize,
    output logic [1:0]          m_axi_Val_awburst,
    output logic                m_axi_Val_awvalid,
    output logic [DATA_W-1:0]   m_axi_Val_wdata,
    output logic [DATA_W/8-1:0] m_axi_Val_wstrb,
    output logic                m_axi_Val_wlast,
    output logic                m_axi_Val_wvalid,
    output logic                m_axi_Val_bready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    fsm_e              state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       remaining;
    logic [31:0]       num_beats;
    logic [31:0]       out_cnt;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] base_al;
    logic [7:0]        first_len;
    logic [7:0]        next_len;
    logic [SUM_W-1:0]  used;
    logic              credit_ok;
    logic              ar_hs;
    logic              r_hs;
    logic              t_hs;
    logic              unused;

    assign m_axi_Val_arsize  = AXI_SIZE_32B;
    assign m_axi_Val_arburst = AXI_BURST_INCR;

    assign m_axi_Val_awaddr  = '0;
    assign m_axi_Val_awlen   = '0;
    assign m_axi_Val_awsize  = '0;
    assign m_axi_Val_awburst = '0;
    assign m_axi_Val_awvalid = 1'b0;
    assign m_axi_Val_wdata   = '0;
    assign m_axi_Val_wstrb   = '0;
    assign m_axi_Val_wlast   = 1'b0;
    assign m_axi_Val_wvalid  = 1'b0;
    assign m_axi_Val_bready  = 1'b1;

    // Beats are counted rather than trusting rlast; low address bits are beat-aligned away.
    assign unused = &{1'b0, cfg_base_addr[4:0], m_axi_Val_rlast};

    assign ar_hs = m_axi_Val_arvalid && m_axi_Val_arready;
    assign r_hs  = m_axi_Val_rvalid && m_axi_Val_rready;
    assign t_hs  = m_axis_tvalid && m_axis_tready;

    assign base_al   = {cfg_base_addr[ADDR_W-1:5], 5'b0};
    assign first_len = burst_len(cfg_base_addr[11:5], cfg_num_beats, 8'(MAX_BURST));
    assign next_len  = burst_len(addr[11:5], remaining, 8'(MAX_BURST));

    // A burst may only be requested if every beat it returns is guaranteed a FIFO slot.
    assign used      = SUM_W'(fifo_count) + SUM_W'(outstanding);
    assign credit_ok = (SUM_W'(FIFO_DEPTH) - used) >= SUM_W'(next_len);

    assign m_axis_tlast = m_axis_tvalid && (out_cnt == num_beats - 32'd1);

    // Beats requested but not yet returned; AR grant and R beat may land together.
    always_comb begin
        outstanding_nxt = outstanding;
        if (ar_hs) begin
            outstanding_nxt = outstanding_nxt + CNT_W'(m_axi_Val_arlen) + CNT_W'(1);
        end
        if (r_hs) begin
            outstanding_nxt = outstanding_nxt - CNT_W'(1);
        end
    end

    // Control FSM. addr/remaining advance when a burst is posted on AR, so the pending
    // burst is never double-counted against credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            addr              <= '0;
            remaining         <= '0;
            num_beats         <= '0;
            out_cnt           <= '0;
            outstanding       <= '0;
            m_axi_Val_arvalid <= 1'b0;
            m_axi_Val_araddr  <= '0;
            m_axi_Val_arlen   <= '0;
            m_axi_Val_rready  <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            done        <= 1'b0;
            outstanding <= outstanding_nxt;
            if (ar_hs) begin
                m_axi_Val_arvalid <= 1'b0;
            end
            if (r_hs && (m_axi_Val_rresp != 2'b00)) begin
                err <= 1'b1;
            end
            if (t_hs) begin
                out_cnt <= out_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_num_beats == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            // Buffer is empty and nothing is outstanding, so the first burst goes out at once.
                            state             <= RUN;
                            busy              <= 1'b1;
                            m_axi_Val_rready  <= 1'b1;
                            err               <= 1'b0;
                            num_beats         <= cfg_num_beats;
                            out_cnt           <= '0;
                            m_axi_Val_araddr  <= base_al;
                            m_axi_Val_arlen   <= first_len - 8'd1;
                            m_axi_Val_arvalid <= 1'b1;
                            addr              <= base_al + (ADDR_W'(first_len) << 5);
                            remaining         <= cfg_num_beats - 32'(first_len);
                        end
                    end
                end
                RUN: begin
                    if (remaining == 32'd0) begin
                        state <= DRAIN;
                    end else if (!m_axi_Val_arvalid && credit_ok) begin
                        m_axi_Val_araddr  <= addr;
                        m_axi_Val_arlen   <= next_len - 8'd1;
                        m_axi_Val_arvalid <= 1'b1;
                        addr              <= addr + (ADDR_W'(next_len) << 5);
                        remaining         <= remaining - 32'(next_len);
                    end
                end
                DRAIN: begin
                    if (!m_axi_Val_arvalid && (outstanding == '0) && (fifo_count == '0)) begin
                        state            <= IDLE;
                        busy             <= 1'b0;
                        m_axi_Val_rready <= 1'b0;
                        done             <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    spmv_stream_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_hs),
        .push_data (m_axi_Val_rdata),
        .pop       (t_hs),
        .pop_data  (m_axis_tdata),
        .valid     (m_axis_tvalid),
        .count     (fifo_count)
    );

endmodule

// File: doc/spmv_val_fetch.md
Name: spmv_val_fetch

Overview:
- Per-kernel AXI4 read master that streams the Val (nonzero value) array of one SpMV kernel out of HBM.
- Sits on the kernel's Val port, upstream of the Val crossbar slave interface, and is programmed from the kernel's config_wire fields.
- Issues INCR read bursts that respect credit limits and 4 KB boundaries.
- Buffers returned beats in a FIFO and presents them as an AXI-Stream to the multiply/accumulate datapath.

Parameters:
- ADDR_W, 48, AXI address width.
- DATA_W, 256, AXI/stream data width; 32 B per beat.
- MAX_BURST, 16, maximum beats per AR burst (arlen ≤ 15).
- FIFO_DEPTH, 64, beat buffer depth; power of two, ≥ MAX_BURST.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a fetch
- cfg_base_addr  in  ADDR_W  Val array byte base; bits [4:0] ignored (forced to 0)
- cfg_num_beats  in  32  number of 32 B beats to fetch
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse after the final stream beat is handshaken
- err  out  1  sticky error: some rresp ≠ 0 during the current fetch
- m_axi_Val_araddr / arlen / arsize / arburst / arvalid  out  ADDR_W / 8 / 3 / 2 / 1  AR channel
- m_axi_Val_arready  in  1
- m_axi_Val_rdata / rresp / rlast / rvalid  in  DATA_W / 2 / 1 / 1  R channel
- m_axi_Val_rready  out  1
- m_axi_Val_aw* / w* / bready  out  —  write side tied off: valids 0, bready 1, data/addr 0
- m_axis_tdata  out  DATA_W  value stream
- m_axis_tvalid  out  1
- m_axis_tlast  out  1  asserted on the final beat of the fetch
- m_axis_tready  in  1

Behaviour:
- Reset values: arvalid 0, araddr 0, arlen 0, busy 0, done 0, err 0, tvalid 0, tlast 0, rready 0.
- Constant outputs: arsize = 3'b101, arburst = 2'b01.
- FSM IDLE:
  - On start with cfg_num_beats = 0: done pulses on the next cycle; no AR is issued; stay in IDLE.
  - Otherwise latch address and remaining count, clear err, enter RUN; busy = 1 from the next cycle.
  - start is ignored while busy.
- FSM RUN:
  - Burst length L = min(MAX_BURST, remaining, beats to the next 4 KB boundary), where beats to boundary = (4096 − addr[11:0]) / 32.
  - arvalid rises one cycle after the start pulse only if FIFO_DEPTH − (fifo_count + outstanding) ≥ L. Otherwise arvalid stays low until space frees.
  - Once raised, arvalid and AR fields hold stable until arready.
  - On AR handshake: addr += 32·L, remaining −= L, outstanding += L.
  - When remaining reaches 0, go to DRAIN.
- FSM DRAIN: wait until outstanding = 0, the FIFO is empty, and the last beat has been handshaken. Then done pulses for 1 cycle, busy falls, return to IDLE.
- R channel:
  - rready = 1 in RUN and DRAIN; credit accounting guarantees FIFO space.
  - Each R handshake pushes rdata into the FIFO and decrements outstanding.
  - Simultaneous AR handshake and R beat update outstanding by +L−1 in the same cycle.
  - rlast is not checked; beats are counted instead.
  - rresp ≠ 0 sets err, and the data is still forwarded.
- Stream output:
  - FIFO is first-word-fall-through; a beat accepted on R at cycle n appears on tvalid at n+1.
  - tlast is driven from a beat counter reaching cfg_num_beats − 1.
  - Simultaneous FIFO push and pop leaves the count unchanged.
- Reset mid-operation: all state, counters and the FIFO clear immediately. Any in-flight AXI transaction is abandoned; system reset also resets the interconnect.
- Width rules:
  - Address arithmetic is ADDR_W bits and wraps silently.
  - Counters are 32 bits.
  - outstanding and fifo_count are $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- spmv_pkg holds: AXI_SIZE_32B = 3'b101, AXI_BURST_INCR = 2'b01, BEAT_BYTES = 32, PAGE_BYTES = 4096, and the fsm_e enum (IDLE, RUN, DRAIN).
- One sub-module: spmv_stream_fifo, a synchronous FWFT FIFO with a count output, parameterised by width and depth.

Test Plan:
- Basic fetch: base 0x1000, num 40, tready = 1 → ARs (0x1000, len 15), (0x1200, len 15), (0x1400, len 7). 40 beats out in order, tlast on beat 40, done pulses once, busy low afterwards.
- 4 KB crossing: base 0x0FC0, num 20 → ARs (0x0FC0, len 1), (0x1000, len 15), (0x1200, len 1). No burst crosses 0x1000.
- Backpressure: num 200, tready = 0 → at most 64 beats accepted. arvalid stays low whenever FIFO_DEPTH − (count + outstanding) < L. Releasing tready resumes fetching; all 200 beats arrive with no loss or duplicates.
- Zero length: start with num 0 → done pulses 1 cycle later; arvalid never asserts; busy stays 0.
- Error response: rresp = 2'b10 on beat 3 → err = 1 from the next cycle and held through done. Beat data still forwarded. The next start clears err.
- Reset mid-burst: assert rst after 5 of 16 beats → arvalid, tvalid and busy drop to 0 asynchronously. After release, a new start with num 8 fetches cleanly.
